// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin Wishbone arbiter in front of the
// PWM/timer register-file slave. A grant is held for a whole cycle (cyc).
// There is always one IDLE cycle between grants. The slave ack is routed
// combinationally to the granted master only.
// Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined, a watchdog
// turns a missing slave ack into a one-cycle err pulse and releases the bus.
// The slave never acks invalid addresses, so without the watchdog such an
// access holds the grant forever.
module wb_arbiter #(
  parameter int unsigned FIRST_GRANT = 0,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [15:0] i_m0_adr,
  input  logic [15:0] i_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_adr,
  input  logic [15:0] i_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  output logic [1:0]  o_gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;      // last granted master: 0 = m0, 1 = m1
  logic   w_req0;
  logic   w_req1;
  logic   w_timeout;   // watchdog expiry in the current cycle

  // Watchdog range is 1..255 because the counter is 8 bits wide; an out-of-range
  // value elaborates this empty marker block so it is easy to spot in a netlist.
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_out_of_range
  end

  assign w_req0 = i_m0_cyc & i_m0_stb;
  assign w_req1 = i_m1_cyc & i_m1_stb;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_tcnt;
  logic       w_sel_stb;

  // Strobe of the granted master, derived from the state register directly.
  always_comb begin
    w_sel_stb = 1'b0;
    case (r_state)
      ST_GNT0: w_sel_stb = i_m0_stb;
      ST_GNT1: w_sel_stb = i_m1_stb;
      ST_IDLE: w_sel_stb = 1'b0;
      default: w_sel_stb = 1'b0;
    endcase
  end

  assign w_timeout = w_sel_stb & ~i_wb_ack & (r_tcnt == TCNT_LAST);

  // Watchdog counter: counts strobed cycles without ack, clears on ack/idle/error.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_tcnt <= 8'd0;
    end else if ((r_state == ST_IDLE) || i_wb_ack || w_timeout) begin
      r_tcnt <= 8'd0;
    end else if (w_sel_stb) begin
      r_tcnt <= r_tcnt + 8'd1;
    end else begin
      r_tcnt <= r_tcnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Last-granted register: updated on entry to a grant state.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_last <= (FIRST_GRANT == 0) ? 1'b1 : 1'b0;
    end else if ((r_state == ST_IDLE) && (w_next == ST_GNT0)) begin
      r_last <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_next == ST_GNT1)) begin
      r_last <= 1'b1;
    end else begin
      r_last <= r_last;
    end
  end

  // Next-state logic: round-robin from IDLE, hold grant while cyc stays high.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_next = r_last ? ST_GNT0 : ST_GNT1;
        end else if (w_req0) begin
          w_next = ST_GNT0;
        end else if (w_req1) begin
          w_next = ST_GNT1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (w_timeout) begin
          w_next = ST_IDLE;
        end else if (i_m0_cyc) begin
          w_next = ST_GNT0;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (w_timeout) begin
          w_next = ST_IDLE;
        end else if (i_m1_cyc) begin
          w_next = ST_GNT1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output routing: the granted master drives the slave, ack/err go back to it only.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_adr  = 16'h0000;
    o_wb_data = 16'h0000;
    o_m0_ack  = 1'b0;
    o_m1_ack  = 1'b0;
    o_m0_err  = 1'b0;
    o_m1_err  = 1'b0;
    o_gnt     = 2'b00;
    case (r_state)
      ST_GNT0: begin
        o_wb_cyc  = i_m0_cyc;
        o_wb_stb  = i_m0_stb;
        o_wb_we   = i_m0_we;
        o_wb_adr  = i_m0_adr;
        o_wb_data = i_m0_data;
        o_m0_ack  = i_wb_ack;
        o_m0_err  = w_timeout;
        o_gnt     = 2'b01;
      end
      ST_GNT1: begin
        o_wb_cyc  = i_m1_cyc;
        o_wb_stb  = i_m1_stb;
        o_wb_we   = i_m1_we;
        o_wb_adr  = i_m1_adr;
        o_wb_data = i_m1_data;
        o_m1_ack  = i_wb_ack;
        o_m1_err  = w_timeout;
        o_gnt     = 2'b10;
      end
      ST_IDLE: begin
        o_gnt = 2'b00;
      end
      default: begin
        o_gnt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Watchdog expectations follow WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [15:0] m0_adr, m0_data;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [15:0] m1_adr, m1_data;
  logic        m1_ack, m1_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr, wb_data;
  logic        wb_ack;
  logic [1:0]  gnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter dut (
    .i_wb_clk (clk),
    .i_wb_rst (rst),
    .i_m0_cyc (m0_cyc),
    .i_m0_stb (m0_stb),
    .i_m0_we  (m0_we),
    .i_m0_adr (m0_adr),
    .i_m0_data(m0_data),
    .o_m0_ack (m0_ack),
    .o_m0_err (m0_err),
    .i_m1_cyc (m1_cyc),
    .i_m1_stb (m1_stb),
    .i_m1_we  (m1_we),
    .i_m1_adr (m1_adr),
    .i_m1_data(m1_data),
    .o_m1_ack (m1_ack),
    .o_m1_err (m1_err),
    .o_wb_cyc (wb_cyc),
    .o_wb_stb (wb_stb),
    .o_wb_we  (wb_we),
    .o_wb_adr (wb_adr),
    .o_wb_data(wb_data),
    .i_wb_ack (wb_ack),
    .o_gnt    (gnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic c, input logic s, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_data = d;
  endtask

  task automatic drive_m1(input logic c, input logic s, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    wb_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {22'd0, gnt, wb_cyc, wb_stb, wb_we, m0_ack, m0_err, m1_ack, m1_err, 1'b0};
  endfunction

  logic [15:0] beat_adr [3];
  int stb_cnt, err_cnt, err_at, err_i, ack_cnt, bad;
  logic [1:0] gnt_after;
  logic err_seen;

  initial begin
    beat_adr[0] = 16'h0000;
    beat_adr[1] = 16'h0004;
    beat_adr[2] = 16'h0006;
    rst = 1'b1;
    wb_ack = 1'b0;
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // ---- Reset state and single m0 write 0x0002 <- 0x00A5 ----
    do_reset();
    @(negedge clk);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_adr_data", {wb_adr, wb_data}, 32'h0);

    cyc_begin(); drive_m0(1'b1, 1'b1, 1'b1, 16'h0002, 16'h00A5);
    @(negedge clk);
    chk("t1_pre_gnt", 32'(gnt), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_slave_adr_data", {wb_adr, wb_data}, 32'h0002_00A5);
    chk("t1_slave_ctl", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd7);
    chk("t1_no_early_ack", 32'(m0_ack), 32'd0);
    cyc_begin(); wb_ack = 1'b1;
    @(negedge clk);
    chk("t1_acks", {30'd0, m1_ack, m0_ack}, 32'd1);
    cyc_begin(); wb_ack = 1'b0; drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("t1_release_gnt", 32'(gnt), 32'd1);
    chk("t1_ack_once", 32'(m0_ack), 32'd0);
    cyc_begin(); wb_ack = 1'b1;
    @(negedge clk);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);
    chk("t1_idle_ack_dropped", {30'd0, m1_ack, m0_ack}, 32'd0);
    wb_ack = 1'b0;

    // ---- Simultaneous contest after reset ----
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1111);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0005, 16'h2222);
    @(negedge clk);
    chk("t2_pre_gnt", 32'(gnt), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk("t2_first_m0", 32'(gnt), 32'd1);
    chk("t2_m0_data", 32'(wb_data), 32'h1111);
    cyc_begin(); wb_ack = 1'b1;
    @(negedge clk);
    chk("t2_m0_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
    cyc_begin(); wb_ack = 1'b0; drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("t2_m0_hold", 32'(gnt), 32'd1);
    cyc_begin();
    @(negedge clk);
    chk("t2_dead_idle", 32'(gnt), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk("t2_then_m1", 32'(gnt), 32'd2);
    chk("t2_m1_adr_we", {15'd0, wb_we, wb_adr}, 32'h0000_0005);
    cyc_begin(); wb_ack = 1'b1;
    @(negedge clk);
    chk("t2_m1_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
    cyc_begin(); wb_ack = 1'b0; drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_begin();
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000);
    @(negedge clk);
    chk("t2_idle2", 32'(gnt), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk("t2_second_m0", 32'(gnt), 32'd1);

    // ---- m1 three-beat block while m0 keeps requesting ----
    cyc_begin(); drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_begin();
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("t3_idle", 32'(gnt), 32'd0);
    for (int b = 0; b < 3; b++) begin
      cyc_begin(); m1_adr = beat_adr[b]; wb_ack = 1'b0;
      @(negedge clk);
      chk("t3_beat_gnt", 32'(gnt), 32'd2);
      chk("t3_beat_adr", 32'(wb_adr), 32'(beat_adr[b]));
      cyc_begin(); wb_ack = 1'b1;
      @(negedge clk);
      chk("t3_beat_ack", {28'd0, gnt, m1_ack, m0_ack}, 32'hA);
    end
    cyc_begin(); wb_ack = 1'b0; drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("t3_release_hold", 32'(gnt), 32'd2);
    cyc_begin();
    @(negedge clk);
    chk("t3_dead_idle", 32'(gnt), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk("t3_m0_after", 32'(gnt), 32'd1);
    cyc_begin(); drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_begin();

    // ---- m0 access to invalid address 0x0003, slave never acks ----
    stb_cnt = 0; err_cnt = 0; err_at = 0; err_i = -10; ack_cnt = 0; bad = 0;
    gnt_after = 2'b11; err_seen = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      cyc_begin();
      if (i == 0) drive_m0(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000);
      if (err_seen) drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      if (i == err_i + 1) gnt_after = gnt;
      if (gnt == 2'b01 && wb_stb) stb_cnt++;
      if (m0_err) begin
        err_cnt++;
        err_at = stb_cnt;
        err_i = i;
        err_seen = 1'b1;
      end
      if (m0_ack || m1_err) ack_cnt++;
    end
    chk("t4_err_count", 32'(err_cnt), 32'd1);
    chk("t4_err_stb_cycle", 32'(err_at), 32'd16);
    chk("t4_no_ack", 32'(ack_cnt), 32'd0);
    chk("t4_idle_after_err", 32'(gnt_after), 32'd0);
`else
    for (int i = 0; i < 101; i++) begin
      cyc_begin();
      if (i == 0) drive_m0(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000);
      @(negedge clk);
      if (i >= 1 && (gnt != 2'b01 || m0_err || m1_err || m0_ack)) bad++;
    end
    chk("t4_held_no_err", 32'(bad), 32'd0);
    chk("t4_final_gnt", 32'(gnt), 32'd1);
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_begin();
`endif
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_begin();
    cyc_begin();

    // ---- Reset while m1 is granted with stb high ----
    drive_m1(1'b1, 1'b1, 1'b1, 16'h0006, 16'h3333);
    cyc_begin();
    @(negedge clk);
    chk("t5_gnt1", {29'd0, gnt, wb_stb}, 32'd5);
    cyc_begin();
    rst = 1'b1;
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0001, 16'h4444);
    cyc_begin();
    rst = 1'b0;
    wb_ack = 1'b1;
    @(negedge clk);
    chk("t5_rst_flags", flags(), 32'h0);
    chk("t5_rst_adr_data", {wb_adr, wb_data}, 32'h0);
`ifdef WB_ARB_TIMEOUT_EN
    chk("t5_tcnt", 32'(dut.r_tcnt), 32'd0);
`endif
    cyc_begin(); wb_ack = 1'b0;
    @(negedge clk);
    chk("t5_contest_m0", 32'(gnt), 32'd1);
    chk("t5_m0_routed", {wb_adr, wb_data}, 32'h0001_4444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
